tabla_phase_sequencer: RTL and testbench
========================================

# tabla_phase_sequencer

Top-level run sequencer between the control-register block, the memory interface and the accelerator core. For each host-initiated run it:
- issues one read (weight/data load) transaction per iteration;
- fires the accelerator `compute_start` pulse and waits for end-of-compute;
- after the final iteration, issues one write-back transaction;
- keeps per-phase cycle counters that the control interface reads back.

## Interface
Parameters:
- ITER_WIDTH, 8, width of iteration count/index
- PERF_CNTR_WIDTH, 10, width of each performance counter

Ports (reset ARESETN, synchronous, active-low; clock ACLK):
- ACLK  in  1  clock
- ARESETN  in  1  synchronous active-low reset
- start  in  1  run request; honoured only in IDLE
- abort  in  1  cancel current run
- num_iter  in  ITER_WIDTH  iterations per run, sampled at accepted start; 0 treated as 1
- rd_req  out  1  read transaction request, held until rd_ready
- rd_ready  in  1  memory interface accepts read request
- rd_done  in  1  read transaction complete (pulse)
- wr_req  out  1  write-back request, held until wr_ready
- wr_ready  in  1  memory interface accepts write request
- wr_done  in  1  write-back complete (pulse)
- compute_start  out  1  one-cycle accelerator start pulse
- eoc  in  1  accelerator end-of-compute
- data_io_dir  out  1  0 = load/compute, 1 = write-back (drives accelerator pop)
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at normal completion
- aborted  out  1  one-cycle pulse when abort takes effect
- iter_idx  out  ITER_WIDTH  current iteration index, 0-based
- total_cycles, rd_cycles, pr_cycles, wr_cycles  out  PERF_CNTR_WIDTH each  cycle counters

## Operation
States: IDLE, RD_REQ, RD_WAIT, COMPUTE, WR_REQ, WR_WAIT, DONE.

- **IDLE:** on start=1 and abort=0:
  - latch max(num_iter, 1) into iter_total;
  - clear iter_idx and all counters;
  - go to RD_REQ.
- **RD_REQ:** rd_req=1. On rd_ready=1 go to RD_WAIT. rd_done is ignored in this state.
- **RD_WAIT:** on rd_done=1 go to COMPUTE.
- **COMPUTE:**
  - compute_start=1 on the first cycle in the state only.
  - eoc is sampled from the second cycle onward, so a stale eoc left high is ignored.
  - On eoc=1: if iter_idx+1 < iter_total, increment iter_idx and go to RD_REQ; otherwise go to WR_REQ.
- **WR_REQ:** wr_req=1, data_io_dir=1. On wr_ready=1 go to WR_WAIT.
- **WR_WAIT:** data_io_dir=1. On wr_done=1 go to DONE.
- **DONE:** done=1 for one cycle, then IDLE. iter_idx holds its final value.

Abort handling:
- abort=1 in any state other than IDLE: next state is IDLE and aborted pulses for one cycle.
- done does not pulse; counters freeze at their current values.
- abort has priority over every other transition, including DONE→IDLE (in DONE, both done and aborted pulse).
- In IDLE, abort=1 blocks start and produces no aborted pulse.

Output decoding:
- rd_req, wr_req and data_io_dir are decoded from the registered state and are therefore glitch-free.
- compute_start and done are registered pulses.

Counters:
- All saturate at all-ones and never wrap.
- total_cycles increments in every state except IDLE and DONE.
- rd_cycles increments in RD_REQ and RD_WAIT.
- pr_cycles increments in COMPUTE.
- wr_cycles increments in WR_REQ and WR_WAIT.
- Values hold after completion until the next accepted start.

## Timing
Reset values of all outputs: rd_req=0, wr_req=0, compute_start=0, data_io_dir=0, busy=0, done=0, aborted=0, iter_idx=0, all counters 0.

Latencies:
- start to rd_req: 1 cycle.
- rd_done to compute_start: 1 cycle.
- eoc to the next rd_req or wr_req: 1 cycle.
- wr_done to done: 1 cycle.
- done to the earliest next start acceptance: 1 cycle (start is accepted on the cycle after done).

Handshake rules:
- rd_req/wr_req remain asserted until the cycle where the matching ready is high, and drop the cycle after.
- A ready and its done asserted in the same cycle: only the ready is consumed and the done is lost. The memory interface guarantees done arrives at least one cycle after ready.

Minimum run, num_iter=1 with all responders answering in one cycle: 7 cycles from start to done.

Reset mid-run: everything returns to reset values on the next edge; no done or aborted pulse.

## Configuration
- TABLA_SEQ_PERF_CNTR_EN defined: the four counters are implemented as described above.
- Not defined: the counter registers are removed and all four counter outputs are tied to 0.
- State-machine behaviour is identical in both builds.

## Test plan
- **Basic single run.** num_iter=1, responders reply one cycle after each request, eoc 5 cycles after compute_start. Expect:
  - one rd_req handshake, one compute_start, one wr_req handshake;
  - done pulse;
  - pr_cycles=6, iter_idx=0.
- **Three iterations.** num_iter=3. Expect:
  - three rd_req handshakes and three compute_start pulses;
  - a single wr_req;
  - iter_idx sequence 0,1,2;
  - data_io_dir high only in the WR phases.
- **num_iter=0.** Expect behaviour identical to num_iter=1.
- **Abort and stale eoc.** Abort in RD_WAIT and again in COMPUTE: expect an aborted pulse, return to IDLE, no done, counters frozen. Hold eoc high when entering COMPUTE: expect no transition until the second COMPUTE cycle.
- **Counter saturation.** With PERF_CNTR_WIDTH=4 and a compute phase of 40 cycles, pr_cycles stops at 15. With the macro undefined, all counters read 0.
- **Start while busy.** A start mid-run is ignored and num_iter is not re-sampled. A start in the cycle after done is accepted and all counters are cleared.

Source files
------------

// File: rtl/tabla_phase_sequencer.sv
// Run sequencer: one read and one compute per iteration, then a single write-back, with per-phase cycle counters.
// Optional feature macro: TABLA_SEQ_PERF_CNTR_EN. When defined, the counters are implemented; otherwise they read 0.
module tabla_phase_sequencer #(
  parameter int unsigned ITER_WIDTH      = 8,
  parameter int unsigned PERF_CNTR_WIDTH = 10
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       start,
  input  logic                       abort,
  input  logic [ITER_WIDTH-1:0]      num_iter,
  output logic                       rd_req,
  input  logic                       rd_ready,
  input  logic                       rd_done,
  output logic                       wr_req,
  input  logic                       wr_ready,
  input  logic                       wr_done,
  output logic                       compute_start,
  input  logic                       eoc,
  output logic                       data_io_dir,
  output logic                       busy,
  output logic                       done,
  output logic                       aborted,
  output logic [ITER_WIDTH-1:0]      iter_idx,
  output logic [PERF_CNTR_WIDTH-1:0] total_cycles,
  output logic [PERF_CNTR_WIDTH-1:0] rd_cycles,
  output logic [PERF_CNTR_WIDTH-1:0] pr_cycles,
  output logic [PERF_CNTR_WIDTH-1:0] wr_cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_COMPUTE, S_WR_REQ, S_WR_WAIT, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ITER_WIDTH-1:0] iter_idx_q, iter_idx_d;
  logic [ITER_WIDTH-1:0] iter_total_q, iter_total_d;
  logic                  cstart_q, cstart_d;
  logic                  aborted_q, aborted_d;
  logic                  clr_cnt;
  logic [ITER_WIDTH:0]   iter_next;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q      <= S_IDLE;
      iter_idx_q   <= '0;
      iter_total_q <= '0;
      cstart_q     <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      iter_idx_q   <= iter_idx_d;
      iter_total_q <= iter_total_d;
      cstart_q     <= cstart_d;
      aborted_q    <= aborted_d;
    end
  end

  assign iter_next = {1'b0, iter_idx_q} + {{ITER_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    state_d      = state_q;
    iter_idx_d   = iter_idx_q;
    iter_total_d = iter_total_q;
    cstart_d     = 1'b0;
    aborted_d    = 1'b0;
    clr_cnt      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          iter_total_d = (num_iter == '0) ? {{(ITER_WIDTH-1){1'b0}}, 1'b1} : num_iter;
          iter_idx_d   = '0;
          clr_cnt      = 1'b1;
          state_d      = S_RD_REQ;
        end
      end
      S_RD_REQ:  if (rd_ready) state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (rd_done) begin
          state_d  = S_COMPUTE;
          cstart_d = 1'b1;
        end
      end
      S_COMPUTE: begin
        // cstart_q marks the first COMPUTE cycle, so an eoc left over from the previous compute is ignored.
        if (!cstart_q && eoc) begin
          if (iter_next < {1'b0, iter_total_q}) begin
            iter_idx_d = iter_next[ITER_WIDTH-1:0];
            state_d    = S_RD_REQ;
          end else begin
            state_d = S_WR_REQ;
          end
        end
      end
      S_WR_REQ:  if (wr_ready) state_d = S_WR_WAIT;
      S_WR_WAIT: if (wr_done) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      iter_idx_d = iter_idx_q;
      cstart_d   = 1'b0;
      aborted_d  = 1'b1;
    end
  end

  assign rd_req        = (state_q == S_RD_REQ);
  assign wr_req        = (state_q == S_WR_REQ);
  assign data_io_dir   = (state_q == S_WR_REQ) || (state_q == S_WR_WAIT);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign compute_start = cstart_q;
  assign aborted       = aborted_q;
  assign iter_idx      = iter_idx_q;

`ifdef TABLA_SEQ_PERF_CNTR_EN
  logic [PERF_CNTR_WIDTH-1:0] total_q, rd_q, pr_q, wr_q;

  function automatic logic [PERF_CNTR_WIDTH-1:0] sat_inc(input logic [PERF_CNTR_WIDTH-1:0] v,
                                                         input logic en);
    if (en && v != '1) return v + {{(PERF_CNTR_WIDTH-1){1'b0}}, 1'b1};
    return v;
  endfunction

  always_ff @(posedge ACLK) begin
    if (!ARESETN || clr_cnt) begin
      total_q <= '0;
      rd_q    <= '0;
      pr_q    <= '0;
      wr_q    <= '0;
    end else begin
      total_q <= sat_inc(total_q, state_q != S_IDLE && state_q != S_DONE);
      rd_q    <= sat_inc(rd_q, state_q == S_RD_REQ || state_q == S_RD_WAIT);
      pr_q    <= sat_inc(pr_q, state_q == S_COMPUTE);
      wr_q    <= sat_inc(wr_q, state_q == S_WR_REQ || state_q == S_WR_WAIT);
    end
  end

  assign total_cycles = total_q;
  assign rd_cycles    = rd_q;
  assign pr_cycles    = pr_q;
  assign wr_cycles    = wr_q;
`else
  assign total_cycles = '0;
  assign rd_cycles    = '0;
  assign pr_cycles    = '0;
  assign wr_cycles    = '0;
`endif

endmodule

// File: tb/tb_tabla_phase_sequencer.sv
// Directed bench for tabla_phase_sequencer; a second instance with 4-bit counters covers saturation.
module tb_tabla_phase_sequencer;

`ifdef TABLA_SEQ_PERF_CNTR_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       ACLK = 1'b0;
  logic       ARESETN = 1'b0;
  logic       start = 1'b0, abort = 1'b0, rd_ready = 1'b0, rd_done = 1'b0;
  logic       wr_ready = 1'b0, wr_done = 1'b0, eoc = 1'b0;
  logic [7:0] num_iter = 8'd0;

  logic       rd_req, wr_req, compute_start, data_io_dir, busy, done, aborted;
  logic [7:0] iter_idx;
  logic [9:0] total_cycles, rd_cycles, pr_cycles, wr_cycles;

  logic       rd_req4, wr_req4, compute_start4, data_io_dir4, busy4, done4, aborted4;
  logic [7:0] iter_idx4;
  logic [3:0] total4, rd4, pr4, wr4;

  always #5 ACLK = ~ACLK;

  tabla_phase_sequencer #(.ITER_WIDTH(8), .PERF_CNTR_WIDTH(10)) u_dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .abort(abort), .num_iter(num_iter),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_done(rd_done),
    .wr_req(wr_req), .wr_ready(wr_ready), .wr_done(wr_done),
    .compute_start(compute_start), .eoc(eoc), .data_io_dir(data_io_dir),
    .busy(busy), .done(done), .aborted(aborted), .iter_idx(iter_idx),
    .total_cycles(total_cycles), .rd_cycles(rd_cycles), .pr_cycles(pr_cycles), .wr_cycles(wr_cycles)
  );

  tabla_phase_sequencer #(.ITER_WIDTH(8), .PERF_CNTR_WIDTH(4)) u_dut4 (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .abort(abort), .num_iter(num_iter),
    .rd_req(rd_req4), .rd_ready(rd_ready), .rd_done(rd_done),
    .wr_req(wr_req4), .wr_ready(wr_ready), .wr_done(wr_done),
    .compute_start(compute_start4), .eoc(eoc), .data_io_dir(data_io_dir4),
    .busy(busy4), .done(done4), .aborted(aborted4), .iter_idx(iter_idx4),
    .total_cycles(total4), .rd_cycles(rd4), .pr_cycles(pr4), .wr_cycles(wr4)
  );

  int errs = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int unsigned pc(input int unsigned v);
    return PERF ? v : 0;
  endfunction

  function automatic int unsigned pc4(input int unsigned v);
    return PERF ? ((v > 15) ? 15 : v) : 0;
  endfunction

  // Monitor/responder state
  int n_rd, n_cs, n_wr, n_done, n_abt, n_dir_err;
  int iter_log[$];
  bit auto_resp = 1'b0;
  bit rd_pend = 1'b0, wr_wait_m = 1'b0;
  int eoc_cnt = 100000;
  int eoc_lat = 1;

  task automatic clear_counts();
    n_rd = 0; n_cs = 0; n_wr = 0; n_done = 0; n_abt = 0; n_dir_err = 0;
    iter_log.delete();
  endtask

  // One cycle: sample outputs at negedge, then drive inputs for the next posedge.
  task automatic tick();
    @(negedge ACLK);
    if (compute_start) begin
      n_cs++;
      iter_log.push_back(int'(iter_idx));
    end
    if (done) n_done++;
    if (aborted) n_abt++;
    if (auto_resp) begin
      if (data_io_dir !== (wr_req | wr_wait_m)) n_dir_err++;
      rd_done   = rd_pend;
      rd_pend   = 1'b0;
      wr_done   = wr_wait_m;
      wr_wait_m = 1'b0;
      rd_ready  = rd_req;
      if (rd_req) begin n_rd++; rd_pend = 1'b1; end
      wr_ready  = wr_req;
      if (wr_req) begin n_wr++; wr_wait_m = 1'b1; end
      if (compute_start) eoc_cnt = 0;
      else if (eoc_cnt < 100000) eoc_cnt++;
      eoc = (eoc_cnt == eoc_lat);
    end
  endtask

  task automatic run(input int ni, input int lat, input bit mid_start, output int cyc);
    clear_counts();
    auto_resp = 1'b1;
    eoc_lat   = lat;
    eoc_cnt   = 100000;
    tick();
    start    = 1'b1;
    num_iter = 8'(ni);
    tick();
    start = 1'b0;
    cyc   = 1;
    check_eq("run_busy_first", busy, 1);
    check_eq("run_cnt_cleared", {total_cycles, rd_cycles, pr_cycles, wr_cycles}, 0);
    while (!done && cyc < 300) begin
      if (mid_start && cyc == 4) begin
        start    = 1'b1;
        num_iter = 8'd5;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check_eq("run_done_seen", done, 1);
  endtask

  task automatic manual_mode();
    auto_resp = 1'b0;
    {start, abort, rd_ready, rd_done, wr_ready, wr_done, eoc} = '0;
  endtask

  int cyc;

  initial begin
    // Reset state
    tick(); tick();
    check_eq("rst_ctrl", {rd_req, wr_req, compute_start, data_io_dir, busy, done, aborted}, 0);
    check_eq("rst_iter", iter_idx, 0);
    check_eq("rst_cnt", {total_cycles, rd_cycles, pr_cycles, wr_cycles}, 0);
    ARESETN = 1'b1;
    tick();

    // Basic single run, eoc 5 cycles after compute_start
    run(1, 5, 1'b0, cyc);
    check_eq("basic_latency", cyc, 11);
    check_eq("basic_hs", {8'(n_rd), 8'(n_cs), 8'(n_wr), 8'(n_done), 8'(n_abt)}, {8'd1, 8'd1, 8'd1, 8'd1, 8'd0});
    check_eq("basic_dir", n_dir_err, 0);
    check_eq("basic_iter", iter_idx, 0);
    check_eq("basic_pr", pr_cycles, pc(6));
    check_eq("basic_total", total_cycles, pc(10));
    check_eq("basic_rd_wr", {rd_cycles, wr_cycles}, {10'(pc(2)), 10'(pc(2))});

    // num_iter=0 behaves as 1; minimum run is 7 cycles
    run(0, 1, 1'b0, cyc);
    check_eq("zero_latency", cyc, 7);
    check_eq("zero_hs", {8'(n_rd), 8'(n_cs), 8'(n_wr)}, {8'd1, 8'd1, 8'd1});
    check_eq("zero_total", total_cycles, pc(6));
    check_eq("zero_iter", iter_idx, 0);

    // Three iterations started the cycle after done; mid-run start with num_iter=5 ignored
    run(3, 1, 1'b1, cyc);
    check_eq("three_latency", cyc, 15);
    check_eq("three_hs", {8'(n_rd), 8'(n_cs), 8'(n_wr), 8'(n_done)}, {8'd3, 8'd3, 8'd1, 8'd1});
    check_eq("three_log_len", iter_log.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < iter_log.size()) check_eq($sformatf("three_idx%0d", i), iter_log[i], i);
    check_eq("three_dir", n_dir_err, 0);
    check_eq("three_final_iter", iter_idx, 2);
    check_eq("three_cnts", {total_cycles, rd_cycles, pr_cycles, wr_cycles},
             {10'(pc(14)), 10'(pc(6)), 10'(pc(6)), 10'(pc(2))});

    // Saturation on the 4-bit instance: compute phase of 41 cycles
    run(1, 40, 1'b0, cyc);
    check_eq("sat_latency", cyc, 46);
    check_eq("sat_pr10", pr_cycles, pc(41));
    check_eq("sat_pr4", pr4, pc4(41));
    check_eq("sat_total4", total4, pc4(45));
    check_eq("sat_rd4", rd4, pc4(2));

    // Abort in IDLE blocks start, no aborted pulse
    manual_mode();
    clear_counts();
    tick(); start = 1'b1; abort = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    check_eq("idle_abort", {busy, aborted}, 0);

    // Abort in RD_WAIT
    tick(); start = 1'b1; num_iter = 8'd2;
    tick(); start = 1'b0; check_eq("ab1_rdreq", rd_req, 1); rd_ready = 1'b1;
    tick(); rd_ready = 1'b0; check_eq("ab1_rdwait", {busy, rd_req}, 2'b10); abort = 1'b1;
    tick(); abort = 1'b0;
    check_eq("ab1_pulse", {aborted, busy, done}, 3'b100);
    check_eq("ab1_cnt", {total_cycles, rd_cycles}, {10'(pc(2)), 10'(pc(2))});
    tick(); check_eq("ab1_single", aborted, 0);
    tick(); check_eq("ab1_frozen", {total_cycles, rd_cycles, pr_cycles}, {10'(pc(2)), 10'(pc(2)), 10'd0});

    // Abort in second COMPUTE cycle
    tick(); start = 1'b1; num_iter = 8'd1;
    tick(); start = 1'b0; rd_ready = 1'b1;
    tick(); rd_ready = 1'b0; rd_done = 1'b1;
    tick(); rd_done = 1'b0; check_eq("ab2_cstart", compute_start, 1);
    tick(); abort = 1'b1;
    tick(); abort = 1'b0;
    check_eq("ab2_pulse", {aborted, busy, compute_start}, 3'b100);
    check_eq("ab2_cnt", {total_cycles, pr_cycles, wr_cycles}, {10'(pc(4)), 10'(pc(2)), 10'd0});
    check_eq("ab_no_done", n_done, 0);
    check_eq("ab_pulses", n_abt, 2);

    // Stale eoc held high into COMPUTE, then abort landing in DONE
    tick(); start = 1'b1; eoc = 1'b1;
    tick(); start = 1'b0; rd_ready = 1'b1;
    tick(); rd_ready = 1'b0; rd_done = 1'b1;
    tick(); rd_done = 1'b0; check_eq("stale_c1", {compute_start, wr_req}, 2'b10);
    tick(); check_eq("stale_c2", {compute_start, wr_req, busy}, 3'b001);
    tick(); eoc = 1'b0; check_eq("stale_wrreq", {wr_req, data_io_dir}, 2'b11); wr_ready = 1'b1;
    tick(); wr_ready = 1'b0; check_eq("stale_wrwait", {wr_req, data_io_dir}, 2'b01); wr_done = 1'b1;
    tick(); wr_done = 1'b0; check_eq("done_abort_d", {done, data_io_dir}, 2'b10); abort = 1'b1;
    tick(); abort = 1'b0; check_eq("done_abort_a", {aborted, done, busy}, 3'b100);
    check_eq("stale_cnt", {total_cycles, pr_cycles}, {10'(pc(6)), 10'(pc(2))});

    // Reset mid-run
    tick(); start = 1'b1; num_iter = 8'd3;
    tick(); start = 1'b0; rd_ready = 1'b1;
    tick(); rd_ready = 1'b0; ARESETN = 1'b0;
    tick(); ARESETN = 1'b1;
    check_eq("midrst_ctrl", {rd_req, wr_req, compute_start, data_io_dir, busy, done, aborted}, 0);
    check_eq("midrst_cnt", {iter_idx, total_cycles, rd_cycles, pr_cycles, wr_cycles}, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
